// File: rtl/isa_line_refill.sv
// Single-line instruction buffer: serves PC fetches from one resident line and
// refills that line from the DDR read FIFO on a miss.
module isa_line_refill #(
  parameter int ISA_WIDTH      = 30,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int PC_WIDTH       = 16,
  parameter int LINE_DEPTH     = 16,
  parameter logic [DDR_ADDR_WIDTH-1:0] ISA_BASE = 28'h0000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_req,
  input  logic [PC_WIDTH-1:0]       fetch_pc,
  input  logic                      flush,
  output logic [ISA_WIDTH-1:0]      ins_out,
  output logic                      ins_valid,
  output logic                      fetch_busy,
  output logic                      ins_read_req,
  output logic [DDR_ADDR_WIDTH-1:0] ins_read_addr,
  output logic [7:0]                ins_read_len,
  input  logic                      ins_reading,
  input  logic [ISA_WIDTH-1:0]      fifo_dout,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en
);

  localparam int OFF_W = $clog2(LINE_DEPTH);
  localparam int TAG_W = PC_WIDTH - OFF_W;
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LINE_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

  state_t                    state_reg, state_next;
  logic [TAG_W-1:0]          line_tag_reg;
  logic                      line_valid_reg;
  logic                      flush_pend_reg;
  logic [TAG_W-1:0]          tag_reg;
  logic [OFF_W-1:0]          off_reg;
  logic [CNT_W-1:0]          issued_cnt_reg;
  logic [CNT_W-1:0]          wr_cnt_reg;
  logic                      rd_en_d_reg;
  logic [ISA_WIDTH-1:0]      ins_out_reg;
  logic                      ins_valid_reg;
  logic [DDR_ADDR_WIDTH-1:0] read_addr_reg;
  logic [ISA_WIDTH-1:0]      line_buf [LINE_DEPTH];

  logic [TAG_W-1:0]    fetch_tag;
  logic [OFF_W-1:0]    fetch_off;
  logic [PC_WIDTH-1:0] line_base;
  logic                hit;
  logic                fill_done;

  assign fetch_tag = fetch_pc[PC_WIDTH-1:OFF_W];
  assign fetch_off = fetch_pc[OFF_W-1:0];
  assign line_base = {fetch_tag, {OFF_W{1'b0}}};
  // A flush in the same cycle as a fetch forces the fetch down the miss path.
  assign hit       = fetch_req && !flush && line_valid_reg && (fetch_tag == line_tag_reg);
  assign fill_done = (wr_cnt_reg == FULL_CNT);

  assign ins_out       = ins_out_reg;
  assign ins_valid     = ins_valid_reg;
  assign ins_read_addr = read_addr_reg;
  assign ins_read_len  = 8'(LINE_DEPTH);

  always_comb begin
    state_next   = state_reg;
    ins_read_req = 1'b0;
    fifo_rd_en   = 1'b0;
    fetch_busy   = (state_reg != IDLE);
    case (state_reg)
      IDLE: if (fetch_req && !hit) state_next = REQ;
      REQ: begin
        ins_read_req = 1'b1;
        if (ins_reading) state_next = FILL;
      end
      FILL: begin
        fifo_rd_en = !fifo_empty && (issued_cnt_reg < FULL_CNT);
        if (fill_done) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      line_tag_reg   <= '0;
      line_valid_reg <= 1'b0;
      flush_pend_reg <= 1'b0;
      tag_reg        <= '0;
      off_reg        <= '0;
      issued_cnt_reg <= '0;
      wr_cnt_reg     <= '0;
      rd_en_d_reg    <= 1'b0;
      ins_out_reg    <= '0;
      ins_valid_reg  <= 1'b0;
      read_addr_reg  <= '0;
    end else begin
      ins_valid_reg <= 1'b0;
      rd_en_d_reg   <= fifo_rd_en;
      if (fifo_rd_en)  issued_cnt_reg <= issued_cnt_reg + CNT_W'(1);
      if (rd_en_d_reg) wr_cnt_reg     <= wr_cnt_reg + CNT_W'(1);
      case (state_reg)
        IDLE: begin
          if (flush) line_valid_reg <= 1'b0;
          if (hit) begin
            ins_out_reg   <= line_buf[fetch_off];
            ins_valid_reg <= 1'b1;
          end else if (fetch_req) begin
            tag_reg        <= fetch_tag;
            off_reg        <= fetch_off;
            read_addr_reg  <= ISA_BASE + DDR_ADDR_WIDTH'(line_base);
            line_valid_reg <= 1'b0;
          end
        end
        REQ: begin
          if (flush) flush_pend_reg <= 1'b1;
          if (ins_reading) begin
            issued_cnt_reg <= '0;
            wr_cnt_reg     <= '0;
            rd_en_d_reg    <= 1'b0;
          end
        end
        FILL: begin
          if (flush) flush_pend_reg <= 1'b1;
          if (fill_done) begin
            line_tag_reg   <= tag_reg;
            line_valid_reg <= !(flush_pend_reg || flush);
          end
        end
        RESP: begin
          ins_out_reg    <= line_buf[off_reg];
          ins_valid_reg  <= 1'b1;
          flush_pend_reg <= 1'b0;
          if (flush) line_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // FIFO data arrives one cycle after the pop, so writes follow the delayed strobe.
  always_ff @(posedge clk) begin
    if (rd_en_d_reg && state_reg == FILL)
      line_buf[wr_cnt_reg[OFF_W-1:0]] <= fifo_dout;
  end

endmodule
